// File: rtl/args_counter_reader.sv
// Snapshot reader for the argument counter bank: captures all N counters on
// start and streams them out one word per valid/ready transfer, index 0 first.
module args_counter_reader #(
  parameter int N      = 2,
  parameter int W      = 32,
  parameter int IW     = 1,
  parameter int RD_CLR = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [N*W-1:0]  counters,
  output logic            cnt_clr,
  output logic            busy,
  output logic [W-1:0]    dout,
  output logic [IW-1:0]   dout_idx,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            dout_last,
  output logic            done,
  output logic            dbg_state
);

  // Handshake: a word moves on a rising edge where dout_valid & dout_ready;
  // while dout_valid is high and dout_ready low, dout/dout_idx/dout_last hold.
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          done_q, done_d;
  logic [W-1:0]  snap_q [N];
  logic          capture;
  logic          xfer;
  logic          at_last;

  assign capture = (state_q == IDLE) && start;
  assign xfer    = (state_q == SEND) && dout_ready;
  assign at_last = (idx_q == IW'(N - 1));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    if (capture) begin
      state_d = SEND;
      idx_d   = '0;
    end else if (xfer) begin
      if (at_last) begin
        state_d = IDLE;
        idx_d   = '0;
        done_d  = 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < N; i++) snap_q[i] <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      if (capture) begin
        for (int i = 0; i < N; i++) snap_q[i] <= counters[i*W +: W];
      end
    end
  end

  // The bank clears on the capture edge itself, so no count falls in a gap.
  assign cnt_clr    = (RD_CLR != 0) && capture;
  assign busy       = (state_q == SEND);
  assign dout_valid = (state_q == SEND);
  assign dout       = (state_q == SEND) ? snap_q[idx_q] : '0;
  assign dout_idx   = idx_q;
  assign dout_last  = (state_q == SEND) && at_last;
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_args_counter_reader.sv
// Bench for args_counter_reader: a read-and-clear and a snapshot-only instance
// share stimulus and are checked against a queue-based model every cycle.
module tb_args_counter_reader;

  localparam int N  = 2;
  localparam int W  = 32;
  localparam int IW = 1;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic           start = 1'b0;
  logic           dout_ready = 1'b0;
  logic [N*W-1:0] counters = '0;

  logic          clr0, busy0, valid0, last0, done0, st0;
  logic [W-1:0]  dout0;
  logic [IW-1:0] idx0;
  logic          clr1, busy1, valid1, last1, done1, st1;
  logic [W-1:0]  dout1;
  logic [IW-1:0] idx1;

  args_counter_reader #(.N(N), .W(W), .IW(IW), .RD_CLR(1)) u_clr (
    .clk(clk), .rst(rst), .start(start), .counters(counters), .cnt_clr(clr0),
    .busy(busy0), .dout(dout0), .dout_idx(idx0), .dout_valid(valid0),
    .dout_ready(dout_ready), .dout_last(last0), .done(done0), .dbg_state(st0)
  );

  args_counter_reader #(.N(N), .W(W), .IW(IW), .RD_CLR(0)) u_snap (
    .clk(clk), .rst(rst), .start(start), .counters(counters), .cnt_clr(clr1),
    .busy(busy1), .dout(dout1), .dout_idx(idx1), .dout_valid(valid1),
    .dout_ready(dout_ready), .dout_last(last1), .done(done1), .dbg_state(st1)
  );

  // behavioural model: pending words of the current snapshot
  logic [W-1:0] m_q[$];
  bit           m_active;
  int           m_pos;
  bit           m_done;

  // scoreboard of words actually accepted from the read-and-clear instance
  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_q[$];
  int busy_cnt, done_cnt, clr_cnt, clr1_cnt;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_active = 1'b0;
    m_pos    = 0;
    m_done   = 1'b0;
  endtask

  task automatic model_edge(input logic st, input logic rdy, input logic [N*W-1:0] cnt);
    m_done = 1'b0;
    if (!m_active) begin
      if (st) begin
        m_q.delete();
        for (int i = 0; i < N; i++) m_q.push_back(cnt[i*W +: W]);
        m_pos    = 0;
        m_active = 1'b1;
      end
    end else if (rdy) begin
      void'(m_q.pop_front());
      m_pos++;
      if (m_q.size() == 0) begin
        m_active = 1'b0;
        m_pos    = 0;
        m_done   = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    logic [W-1:0]  e_dout;
    logic [IW-1:0] e_idx;
    logic          e_last;
    e_dout = m_active ? m_q[0] : '0;
    e_idx  = IW'(m_pos);
    e_last = m_active && (m_q.size() == 1);
    chk("busy0",  busy0,  m_active);
    chk("valid0", valid0, m_active);
    chk("dout0",  dout0,  e_dout);
    chk("idx0",   idx0,   e_idx);
    chk("last0",  last0,  e_last);
    chk("done0",  done0,  m_done);
    chk("clr0",   clr0,   !m_active && start);
    chk("busy1",  busy1,  m_active);
    chk("valid1", valid1, m_active);
    chk("dout1",  dout1,  e_dout);
    chk("idx1",   idx1,   e_idx);
    chk("last1",  last1,  e_last);
    chk("done1",  done1,  m_done);
    chk("clr1",   clr1,   1'b0);
  endtask

  // driver: one clock cycle with the given inputs
  task automatic step(input logic st, input logic rdy, input logic [N*W-1:0] cnt);
    @(negedge clk);
    start      = st;
    dout_ready = rdy;
    counters   = cnt;
    #1;
    compare_all();
    if (valid0 && rdy) got_q.push_back(dout0);
    if (busy0) busy_cnt++;
    if (done0) done_cnt++;
    if (clr0)  clr_cnt++;
    if (clr1)  clr1_cnt++;
    @(posedge clk);
    model_edge(st, rdy, cnt);
  endtask

  task automatic clear_log();
    got_q.delete();
    exp_q.delete();
    busy_cnt = 0;
    done_cnt = 0;
    clr_cnt  = 0;
    clr1_cnt = 0;
  endtask

  task automatic check_words(input string name);
    chk({name, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(name, got_q[i], exp_q[i]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    start      = 1'b0;
    dout_ready = 1'b0;
    rst        = 1'b1;
    #1;
    model_reset();
    chk("rst_busy0",  busy0,  1'b0);
    chk("rst_valid0", valid0, 1'b0);
    chk("rst_done0",  done0,  1'b0);
    chk("rst_dout0",  dout0,  '0);
    chk("rst_last0",  last0,  1'b0);
    chk("rst_busy1",  busy1,  1'b0);
    chk("rst_valid1", valid1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  localparam logic [N*W-1:0] C_BASIC = {32'h5, 32'hA};
  localparam logic [N*W-1:0] C_FF    = {32'hFF, 32'hFF};
  localparam logic [N*W-1:0] C_SECOND = {32'h7, 32'h6};
  localparam logic [N*W-1:0] C_AFTER  = {32'h9, 32'h8};

  initial begin
    model_reset();
    clear_log();
    #2;
    compare_all();
    @(negedge clk);
    rst = 1'b0;

    // basic read
    clear_log();
    step(1'b1, 1'b1, C_BASIC);
    step(1'b0, 1'b1, C_BASIC);
    step(1'b0, 1'b1, C_BASIC);
    step(1'b0, 1'b1, C_BASIC);
    step(1'b0, 1'b1, C_BASIC);
    exp_q = '{32'hA, 32'h5};
    check_words("basic_word");
    chk("basic_busy_cycles", busy_cnt, 2);
    chk("basic_done_pulses", done_cnt, 1);
    chk("basic_clr0_pulses", clr_cnt, 1);
    chk("basic_clr1_pulses", clr1_cnt, 0);

    // backpressure on word 0
    clear_log();
    step(1'b1, 1'b1, C_BASIC);
    repeat (3) step(1'b0, 1'b0, C_BASIC);
    repeat (3) step(1'b0, 1'b1, C_BASIC);
    exp_q = '{32'hA, 32'h5};
    check_words("bp_word");
    chk("bp_busy_cycles", busy_cnt, 5);
    chk("bp_done_pulses", done_cnt, 1);

    // snapshot coherence
    clear_log();
    step(1'b1, 1'b1, C_BASIC);
    repeat (3) step(1'b0, 1'b1, C_FF);
    exp_q = '{32'hA, 32'h5};
    check_words("coh_word");

    // ignored start in SEND, back-to-back start in the done cycle
    clear_log();
    step(1'b1, 1'b1, C_BASIC);
    step(1'b1, 1'b1, C_SECOND);
    step(1'b1, 1'b1, C_SECOND);
    step(1'b1, 1'b1, C_SECOND);
    repeat (3) step(1'b0, 1'b1, C_FF);
    exp_q = '{32'hA, 32'h5, 32'h6, 32'h7};
    check_words("b2b_word");
    chk("b2b_done_pulses", done_cnt, 2);
    chk("b2b_busy_cycles", busy_cnt, 4);

    // reset mid-stream
    clear_log();
    step(1'b1, 1'b1, C_BASIC);
    step(1'b0, 1'b1, C_BASIC);
    do_reset();
    step(1'b1, 1'b1, C_AFTER);
    repeat (3) step(1'b0, 1'b1, C_AFTER);
    exp_q = '{32'hA, 32'h8, 32'h9};
    check_words("rst_word");
    chk("rst_done_pulses", done_cnt, 1);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      logic [N*W-1:0] c;
      for (int i = 0; i < N; i++) c[i*W +: W] = $urandom;
      if ($urandom_range(0, 149) == 0) do_reset();
      step($urandom_range(0, 3) == 0, $urandom_range(0, 9) < 7, c);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/args_counter_reader.md
Name: args_counter_reader

Overview:
- Read-out side of the argument counter bank: captures a coherent snapshot of the N×W packed counter bus on request and streams it out one W-bit word per transfer over a valid/ready interface.
- Optionally clears the counter bank through its clear input in the same cycle as the snapshot (read-and-clear).
- Sits between the counter bank and the debug/CSR readout path.

Parameters:
- N, 2, number of counters in the packed input bus.
- W, 32, counter/word width in bits.
- IW, 1, index width; 2^IW >= N is required.
- RD_CLR, 1, 1 = read-and-clear enabled, 0 = snapshot only (cnt_clr never asserted).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  read request; sampled only in IDLE.
- counters  input  N*W  packed counter values; counter i occupies bits [i*W +: W].
- cnt_clr  output  1  clear pulse to the counter bank; combinational.
- busy  output  1  high while a snapshot is being streamed.
- dout  output  W  current word.
- dout_idx  output  IW  index of the counter carried by dout.
- dout_valid  output  1  word valid.
- dout_ready  input  1  sink accepts the word.
- dout_last  output  1  high with the word for index N-1.
- done  output  1  one-cycle pulse after the last word is accepted.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state = IDLE, idx = 0, snapshot register = 0;
  - busy = 0, dout_valid = 0, dout_last = 0, done = 0, dout = 0, dout_idx = 0.
  - Reset mid-stream abandons the stream; no done pulse is produced.
- States: IDLE and SEND.
- IDLE:
  - busy = 0, dout_valid = 0.
  - If start = 1 at a rising edge: the snapshot register loads `counters`, idx loads 0, state goes to SEND.
  - start while in SEND is ignored; start is not queued.
- cnt_clr:
  - cnt_clr = RD_CLR & start & (state == IDLE), combinational.
  - The counter bank clears on the same edge on which the snapshot is captured, so no count between snapshot and clear is lost.
  - An increment asserted in that same cycle is dropped, because clear has priority in the counter bank. This is accepted behaviour.
- SEND:
  - busy = 1, dout_valid = 1.
  - dout = snapshot[idx*W +: W], dout_idx = idx, dout_last = (idx == N-1).
  - Outputs are held stable while dout_valid & ~dout_ready.
  - A transfer occurs at an edge where dout_valid & dout_ready.
  - Non-last transfer: idx increments.
  - Last transfer: state goes to IDLE and done is registered high for exactly the next cycle.
- Back-to-back reads: start asserted during the done cycle (state is already IDLE) is accepted and captures a new snapshot.
- The snapshot is immune to counter activity after capture. Values are reported exactly, with no saturation and no width change; wrap-around of the counters is the counter bank's concern.
- N = 1: a single word is sent with dout_last = 1.
- dout_ready held high gives one word per cycle: N cycles from the capture edge to the last transfer.

Test Plan:
- Basic read, N=2, W=32, RD_CLR=1: counters = {32'h5, 32'hA}, 1-cycle start, dout_ready = 1 → cnt_clr high in the start cycle; words 0x0000000A (idx 0) then 0x00000005 (idx 1, dout_last = 1); done pulses one cycle later; busy high for exactly 2 cycles.
- Backpressure: same read with dout_ready low for 3 cycles on word 0 → dout = 0x0000000A and dout_valid held stable for those 3 cycles; no idx advance; total stream length 5 cycles.
- Snapshot coherence: counters change to {32'hFF, 32'hFF} the cycle after capture → the streamed words remain 0x0A and 0x05.
- RD_CLR=0: start → cnt_clr never asserts; the stream is identical to the basic read.
- Ignored and back-to-back starts: start pulsed during SEND → no restart and no extra words. start in the done cycle → a new capture with 2 further words.
- Reset mid-stream: rst asserted after word 0 is accepted → dout_valid and busy drop immediately (asynchronously); no done pulse; the next start streams from idx 0.
